credit_return_buffer: RTL
=========================

// Module: credit_return_buffer
// PURPOSE
//  Output buffer placed directly downstream of a fixed-latency, non-stallable delay pipeline.
//  Upstream issues a beat only while it holds a credit. The beat leaves the pipeline LATENCY
//  cycles later and is written here. This block presents it as a ready/valid stream and
//  returns the credit when the beat is consumed, so backpressure never has to stall the pipe.
// PARAMETERS
//  cfg      pe_cfg_t  -    PE build configuration; not used for sizing.
//  WIDTH    16             data width in bits; must be >= 1.
//  DEPTH    8              buffer entries = credits; must be >= 1; $fatal at elaboration otherwise.
//  LATENCY  4              issue-to-arrival latency of the upstream pipe. Elaboration $warning if
//                          DEPTH < LATENCY+2 (full throughput not reachable).
// PORTS
//  clock          in   1      single clock; all state on posedge.
//  resetn         in   1      asynchronous assert, active-low; deassert synchronised externally.
//  i_issue        in   1      upstream launches a beat into the pipe this cycle.
//  o_can_issue    out  1      registered; 1 = at least one credit held.
//  i_valid        in   1      beat arriving from pipe output this cycle.
//  i_data         in   WIDTH  arriving beat payload.
//  o_valid        out  1      buffer head valid.
//  o_data         out  WIDTH  buffer head payload.
//  i_ready        in   1      consumer accepts head when o_valid&i_ready (pop).
//  o_err          out  2      sticky: [0] issue without credit, [1] write while full.
// BEHAVIOUR
//  - Reset (resetn=0, async): credits=DEPTH, o_can_issue=1, rd/wr ptr=0, count=0,
//    o_valid=0, o_err=0, o_data=0.
//    Reset mid-operation discards all buffered beats and in-flight credit state immediately.
//  - Storage: circular buffer of DEPTH x WIDTH; wr_ptr, rd_ptr wrap DEPTH-1 -> 0 for any DEPTH
//    (not only powers of 2); count width $clog2(DEPTH+1).
//  - Write: i_valid & (count<DEPTH) -> mem[wr_ptr]<=i_data, wr_ptr++.
//    i_valid while full -> beat dropped, o_err[1]<=1.
//  - Pop: o_valid & i_ready -> rd_ptr++. o_valid=(count!=0), o_data=mem[rd_ptr] (registered store,
//    so 1-cycle write-to-o_valid latency).
//  - Simultaneous write+pop: count unchanged. Write while full+pop same cycle is still overflow
//    (full test uses pre-pop count).
//  - Credits: credits_nxt = credits - (i_issue & o_can_issue) + pop;
//    o_can_issue <= (credits_nxt != 0).
//    Credit returned by a pop is visible on o_can_issue the next cycle.
//    i_issue while o_can_issue=0 -> not counted, o_err[0]<=1. Counter never under/overflows.
//  - Issue+pop same cycle at credits==1: credits stays 1, o_can_issue stays 1.
//  - Round trip issue->credit back = LATENCY+2 cycles; DEPTH >= LATENCY+2 sustains 1 beat/cycle.
//  - o_err bits clear only on reset.
// CONFIGURATION
//  CREDIT_RETURN_BUFFER_BYPASS_EN defined: when count==0 & i_valid, o_valid=1 and o_data=i_data
//    combinationally in the same cycle.
//    If i_ready also 1: beat consumed, not written, credit returned as a pop.
//    Otherwise the beat is written normally. Latency through block = 0.
//  Undefined: no combinational input->output path; minimum latency through block = 1 cycle;
//    o_valid/o_data depend only on state.
// TESTING
//  1 Reset: hold resetn=0 -> o_can_issue=1, o_valid=0, o_err=0.
//    Pulse resetn low with 3 beats buffered -> o_valid=0, credits=DEPTH at once.
//  2 Streaming: DEPTH=8, LATENCY=4, i_ready=1, issue every cycle for 100 cycles ->
//    100 beats out in order, o_can_issue never drops, o_err=0.
//  3 Backpressure: i_ready=0, issue while allowed -> exactly 8 issues accepted, o_can_issue=0.
//    Then i_ready=1 -> o_can_issue=1 the cycle after the first pop, data 0..7 in order.
//  4 Wrap: DEPTH=5 (non-power-of-2), random i_ready, 1000 beats ->
//    scoreboard match, pointers wrap 4->0 cleanly.
//  5 Errors: drive i_issue with o_can_issue=0 -> o_err=2'b01, credits unchanged.
//    Inject i_valid while full -> o_err[1]=1, stored data intact.
//  6 Bypass (macro on): empty buffer, i_valid=1, i_ready=1, i_data=0xA5 ->
//    o_valid=1, o_data=0xA5 same cycle, count stays 0.
//    Macro off: o_valid rises next cycle.

Source files
------------

// File: rtl/credit_return_buffer.sv
// rtl/credit_return_buffer.sv - credit-managed output buffer behind a fixed-latency, non-stallable pipe
// Optional feature macro: CREDIT_RETURN_BUFFER_BYPASS_EN (zero-latency bypass when the buffer is empty).
module credit_return_buffer #(
  parameter type     pe_cfg_t = logic [31:0],
  parameter pe_cfg_t cfg      = '0,
  parameter int      WIDTH    = 16,
  parameter int      DEPTH    = 8,
  parameter int      LATENCY  = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             i_issue,
  output logic             o_can_issue,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready,
  output logic [1:0]       o_err
);
  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW   = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (DEPTH < 1 || WIDTH < 1 || $bits(cfg) < 1) begin : g_bad_cfg
    $fatal(1, "credit_return_buffer: DEPTH and WIDTH must be >= 1");
  end
  if (DEPTH < LATENCY + 2) begin : g_slow_cfg
    $warning("credit_return_buffer: DEPTH < LATENCY+2, full throughput not reachable");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, credits, credits_nxt;
  logic [CW:0]      credits_sum;
  logic             can_issue_q;
  logic [1:0]       err_q;
  logic             empty, full, issue_ok, overflow, wr_en, pop, pop_mem;

  assign empty    = (count == '0);
  assign full     = (count == FULL);
  assign issue_ok = i_issue & can_issue_q;
  assign overflow = i_valid & full;

`ifdef CREDIT_RETURN_BUFFER_BYPASS_EN
  // An arriving beat consumed straight through the bypass never occupies an entry.
  assign o_valid = ~empty | i_valid;
  assign o_data  = !empty ? mem[rd_ptr] : (i_valid ? i_data : '0);
  assign wr_en   = i_valid & ~full & ~(empty & i_ready);
`else
  assign o_valid = ~empty;
  assign o_data  = empty ? '0 : mem[rd_ptr];
  assign wr_en   = i_valid & ~full;
`endif

  // pop returns a credit (bypass included); pop_mem advances the stored head only.
  assign pop     = o_valid & i_ready;
  assign pop_mem = ~empty & i_ready;

  always_comb begin
    credits_sum = {1'b0, credits} + {{CW{1'b0}}, pop} - {{CW{1'b0}}, issue_ok};
    credits_nxt = credits_sum[CW-1:0];
    if (credits_sum > {1'b0, FULL}) begin
      credits_nxt = FULL;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      credits     <= FULL;
      can_issue_q <= 1'b1;
      err_q       <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_mem) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      count       <= count + CW'(wr_en) - CW'(pop_mem);
      credits     <= credits_nxt;
      can_issue_q <= (credits_nxt != '0);
      err_q       <= err_q | {overflow, i_issue & ~can_issue_q};
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= i_data;
    end
  end

  assign o_can_issue = can_issue_q;
  assign o_err       = err_q;
endmodule
